// File: rtl/norm_shift_sequencer.sv
// norm_shift_sequencer: multi-cycle post-add normalizer driving an external leading-one codec
module norm_shift_sequencer #(
   parameter int W_MANT = 26,
   parameter int W_EXP  = 8,
   parameter int W_CNT  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [W_MANT-1:0] mant_i,
   input  logic [W_EXP-1:0]  exp_i,
   output logic [W_MANT-1:0] lzd_data_o,
   input  logic [W_CNT-1:0]  lzd_count_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [W_MANT-1:0] mant_o,
   output logic [W_EXP-1:0]  exp_o,
   output logic              zero_o,
   output logic              ovf_o,
   output logic              unf_o
);
   localparam int WE1 = W_EXP + 1;
   typedef enum logic [1:0] {IDLE, ENC, SHIFT, DONE} state_t;
   state_t            r_state;
   logic [W_MANT-1:0] r_mant;
   logic [W_EXP-1:0]  r_exp;
   logic [W_CNT-1:0]  r_cnt;
   logic              r_zero;
   logic [W_CNT-1:0]  w_s;
   logic [WE1-1:0]    w_exp_inc;
   logic [WE1-1:0]    w_exp_dec;
   logic              w_carry;
   logic              w_ovf;
   logic              w_unf;
   assign w_s       = r_cnt - 1'b1;
   assign w_carry   = r_mant[W_MANT-1];
   assign w_exp_inc = {1'b0, r_exp} + 1'b1;
   assign w_exp_dec = {1'b0, r_exp} - WE1'(w_s);
   assign w_ovf     = w_exp_inc >= WE1'((1 << W_EXP) - 1);
   // borrow or zero in exp-s means s >= exp
   assign w_unf     = (w_s != '0) && (w_exp_dec[W_EXP] || w_exp_dec == '0);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         in_ready_o  <= 1'b1;
         out_valid_o <= 1'b0;
         lzd_data_o  <= '0;
         mant_o      <= '0;
         exp_o       <= '0;
         zero_o      <= 1'b0;
         ovf_o       <= 1'b0;
         unf_o       <= 1'b0;
         r_mant      <= '0;
         r_exp       <= '0;
         r_cnt       <= '0;
         r_zero      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid_i) begin
               r_mant     <= mant_i;
               r_exp      <= exp_i;
               lzd_data_o <= ~mant_i;
               in_ready_o <= 1'b0;
               r_state    <= ENC;
            end
            ENC: begin
               r_cnt      <= lzd_count_i;
               r_zero     <= r_mant == '0;
               lzd_data_o <= '0;
               r_state    <= SHIFT;
            end
            SHIFT: begin
               zero_o      <= r_zero;
               ovf_o       <= !r_zero && w_carry && w_ovf;
               unf_o       <= !r_zero && !w_carry && w_unf;
               mant_o      <= r_zero ? '0 : w_carry ? (w_ovf ? '0 : r_mant >> 1) : (w_unf ? '0 : r_mant << w_s);
               exp_o       <= r_zero ? '0 : w_carry ? (w_ovf ? '1 : w_exp_inc[W_EXP-1:0]) : (w_unf ? '0 : w_exp_dec[W_EXP-1:0]);
               out_valid_o <= 1'b1;
               r_state     <= DONE;
            end
            DONE: if (out_ready_i) begin
               out_valid_o <= 1'b0;
               in_ready_o  <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_norm_shift_sequencer.sv
// tb_norm_shift_sequencer: directed checks of the normalizer with a behavioural leading-one codec
module tb_norm_shift_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [25:0] mant_i = '0;
   logic [7:0]  exp_i = '0;
   logic [25:0] lzd_data_o;
   logic [4:0]  lzd_count_i;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [25:0] mant_o;
   logic [7:0]  exp_o;
   logic        zero_o, ovf_o, unf_o;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [37:0] snap;

   norm_shift_sequencer dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .mant_i(mant_i), .exp_i(exp_i), .lzd_data_o(lzd_data_o), .lzd_count_i(lzd_count_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .mant_o(mant_o), .exp_o(exp_o),
      .zero_o(zero_o), .ovf_o(ovf_o), .unf_o(unf_o)
   );

   always #5 clk = ~clk;

   // all-ones input is undefined for the codec; return junk to prove it is ignored
   function automatic logic [4:0] lead_ones(input logic [25:0] d);
      for (int i = 25; i >= 0; i--) if (!d[i]) return 5'(25 - i);
      return 5'd31;
   endfunction
   assign lzd_count_i = lead_ones(lzd_data_o);

   function automatic logic [37:0] res();
      return {out_valid_o, mant_o, exp_o, zero_o, ovf_o, unf_o};
   endfunction

   task automatic start_op(input logic [25:0] m, input logic [7:0] e);
      @(negedge clk);
      in_valid_i = 1'b1; mant_i = m; exp_i = e;
      @(negedge clk);
      in_valid_i = 1'b0;
   endtask

   task automatic to_done(input logic [25:0] m, input logic [7:0] e);
      start_op(m, e);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic release_done();
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({in_ready_o, res(), lzd_data_o} !== {1'b1, 38'h0, 26'h0}) begin
         n_fail++;
         $display("FAIL reset: got rdy=%b res=%h lzd=%h, want rdy=1 res=0 lzd=0", in_ready_o, res(), lzd_data_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      start_op(26'h1000000, 8'd127);
      n_tests++;
      if ({in_ready_o, out_valid_o, lzd_data_o} !== {1'b0, 1'b0, 26'h2FFFFFF}) begin
         n_fail++;
         $display("FAIL enc_phase: got rdy=%b vld=%b lzd=%h, want 0 0 2ffffff", in_ready_o, out_valid_o, lzd_data_o);
      end
      @(negedge clk);
      n_tests++;
      if ({out_valid_o, lzd_data_o} !== 27'h0) begin
         n_fail++;
         $display("FAIL shift_phase: got vld=%b lzd=%h, want 0 0", out_valid_o, lzd_data_o);
      end
      @(negedge clk);
      n_tests++;
      if (res() !== {1'b1, 26'h1000000, 8'd127, 3'b000}) begin
         n_fail++;
         $display("FAIL t1_norm: got %h want %h", res(), {1'b1, 26'h1000000, 8'd127, 3'b000});
      end
      release_done();
      n_tests++;
      if ({out_valid_o, in_ready_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL t1_release: got vld=%b rdy=%b, want 0 1", out_valid_o, in_ready_o);
      end
   endtask

   task automatic test_carry();
      to_done(26'h2000001, 8'd127);
      n_tests++;
      if (res() !== {1'b1, 26'h1000000, 8'd128, 3'b000}) begin
         n_fail++;
         $display("FAIL carry_127: got %h want %h", res(), {1'b1, 26'h1000000, 8'd128, 3'b000});
      end
      release_done();
      to_done(26'h2000001, 8'd253);
      n_tests++;
      if (res() !== {1'b1, 26'h1000000, 8'd254, 3'b000}) begin
         n_fail++;
         $display("FAIL carry_253: got %h want %h", res(), {1'b1, 26'h1000000, 8'd254, 3'b000});
      end
      release_done();
      to_done(26'h2000001, 8'd254);
      n_tests++;
      if (res() !== {1'b1, 26'h0, 8'd255, 3'b010}) begin
         n_fail++;
         $display("FAIL carry_ovf: got %h want %h", res(), {1'b1, 26'h0, 8'd255, 3'b010});
      end
      release_done();
   endtask

   task automatic test_shift_left();
      to_done(26'h0000001, 8'd127);
      n_tests++;
      if (res() !== {1'b1, 26'h1000000, 8'd103, 3'b000}) begin
         n_fail++;
         $display("FAIL shl_127: got %h want %h", res(), {1'b1, 26'h1000000, 8'd103, 3'b000});
      end
      release_done();
      to_done(26'h0000001, 8'd10);
      n_tests++;
      if (res() !== {1'b1, 26'h0, 8'd0, 3'b001}) begin
         n_fail++;
         $display("FAIL shl_unf10: got %h want %h", res(), {1'b1, 26'h0, 8'd0, 3'b001});
      end
      release_done();
      to_done(26'h0000001, 8'd24);
      n_tests++;
      if (res() !== {1'b1, 26'h0, 8'd0, 3'b001}) begin
         n_fail++;
         $display("FAIL shl_unf_eq: got %h want %h", res(), {1'b1, 26'h0, 8'd0, 3'b001});
      end
      release_done();
      to_done(26'h0000001, 8'd25);
      n_tests++;
      if (res() !== {1'b1, 26'h1000000, 8'd1, 3'b000}) begin
         n_fail++;
         $display("FAIL shl_exp25: got %h want %h", res(), {1'b1, 26'h1000000, 8'd1, 3'b000});
      end
      release_done();
      to_done(26'h1000000, 8'd0);
      n_tests++;
      if (res() !== {1'b1, 26'h1000000, 8'd0, 3'b000}) begin
         n_fail++;
         $display("FAIL shl_s0_exp0: got %h want %h", res(), {1'b1, 26'h1000000, 8'd0, 3'b000});
      end
      release_done();
      to_done(26'h0012345, 8'd100);
      n_tests++;
      if (res() !== {1'b1, 26'h1234500, 8'd92, 3'b000}) begin
         n_fail++;
         $display("FAIL shl_mid: got %h want %h", res(), {1'b1, 26'h1234500, 8'd92, 3'b000});
      end
      release_done();
   endtask

   task automatic test_zero();
      to_done(26'h0, 8'd90);
      n_tests++;
      if (res() !== {1'b1, 26'h0, 8'd0, 3'b100}) begin
         n_fail++;
         $display("FAIL zero: got %h want %h", res(), {1'b1, 26'h0, 8'd0, 3'b100});
      end
      release_done();
   endtask

   task automatic test_backpressure();
      start_op(26'h0012345, 8'd100);
      in_valid_i = 1'b1; mant_i = 26'h3FFFFFF; exp_i = 8'd1;
      @(negedge clk);
      in_valid_i = 1'b0;
      @(negedge clk);
      snap = {1'b1, 26'h1234500, 8'd92, 3'b000};
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if ({in_ready_o, res()} !== {1'b0, snap}) begin
            n_fail++;
            $display("FAIL hold_%0d: got rdy=%b res=%h, want rdy=0 res=%h", k, in_ready_o, res(), snap);
         end
         @(negedge clk);
      end
      release_done();
      n_tests++;
      if ({out_valid_o, in_ready_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL hold_release: got vld=%b rdy=%b, want 0 1", out_valid_o, in_ready_o);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if ({out_valid_o, in_ready_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL no_capture: got vld=%b rdy=%b, want 0 1", out_valid_o, in_ready_o);
      end
   endtask

   task automatic test_mid_reset();
      logic seen;
      start_op(26'h0000001, 8'd127);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if ({in_ready_o, res(), lzd_data_o} !== {1'b1, 38'h0, 26'h0}) begin
         n_fail++;
         $display("FAIL mid_reset: got rdy=%b res=%h lzd=%h, want rdy=1 res=0 lzd=0", in_ready_o, res(), lzd_data_o);
      end
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen |= out_valid_o;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_pulse: got vld seen=%b want 0", seen);
      end
      to_done(26'h1000000, 8'd127);
      n_tests++;
      if (res() !== {1'b1, 26'h1000000, 8'd127, 3'b000}) begin
         n_fail++;
         $display("FAIL post_reset_op: got %h want %h", res(), {1'b1, 26'h1000000, 8'd127, 3'b000});
      end
      release_done();
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_carry();
      test_shift_left();
      test_zero();
      test_backpressure();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
